// File: rtl/instruction_fetch_unit_if.sv
// Bus between the IF stage and its neighbours: hazard/redirect controls,
// the instruction-memory port and the IF/ID register contents.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              stall;
    logic              flush;
    logic              pc_write;
    logic [ADDR_W-1:0] pc_write_back_value;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic [15:0]       instruction_r;
    logic [15:0]       immediate_r;
    logic [ADDR_W-1:0] pc_plus_one_r;
    logic              valid_r;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output stall, flush, pc_write, pc_write_back_value, imem_data,
        input  imem_addr, instruction_r, immediate_r, pc_plus_one_r, valid_r, pc_out
    );

    modport slave (
        input  stall, flush, pc_write, pc_write_back_value, imem_data,
        output imem_addr, instruction_r, immediate_r, pc_plus_one_r, valid_r, pc_out
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: boots the PC from imem, assembles two-word
// (opcode + immediate) instructions and loads the IF/ID register.
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W            = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR_ADDR = 16'h0000,
    parameter logic [4:0]        TWO_WORD_OPCODE   = 5'b11000,
    parameter logic [15:0]       NOP_WORD          = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        BOOT      = 2'b00,
        FETCH_OP  = 2'b01,
        FETCH_IMM = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [15:0]       hold_op_r;
    logic [15:0]       hold_op_nxt_s;
    logic [15:0]       instr_r;
    logic [15:0]       instr_nxt_s;
    logic [15:0]       imm_r;
    logic [15:0]       imm_nxt_s;
    logic [ADDR_W-1:0] ppo_r;
    logic [ADDR_W-1:0] ppo_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              bubble_s;

    function automatic logic is_two_word(input logic [15:0] word);
        return (word[15:11] == TWO_WORD_OPCODE);
    endfunction

    // Boot reads the vector slot; afterwards the PC drives memory directly.
    assign bus.imem_addr     = (state_r == BOOT) ? RESET_VECTOR_ADDR : pc_r;
    assign bus.instruction_r = instr_r;
    assign bus.immediate_r   = imm_r;
    assign bus.pc_plus_one_r = ppo_r;
    assign bus.valid_r       = valid_r;
    assign bus.pc_out        = pc_r;

    assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state and IF/ID load selection; priority pc_write > flush > stall.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        hold_op_nxt_s = hold_op_r;
        instr_nxt_s   = instr_r;
        imm_nxt_s     = imm_r;
        ppo_nxt_s     = ppo_r;
        valid_nxt_s   = valid_r;
        bubble_s      = 1'b0;
        case (state_r)
            BOOT: begin
                pc_nxt_s    = ADDR_W'(bus.imem_data);
                bubble_s    = 1'b1;
                state_nxt_s = FETCH_OP;
            end
            FETCH_OP: begin
                if (bus.pc_write) begin
                    pc_nxt_s = bus.pc_write_back_value;
                    bubble_s = 1'b1;
                end else if (bus.flush) begin
                    bubble_s = 1'b1;
                end else if (bus.stall) begin
                    state_nxt_s = state_r;
                end else if (is_two_word(bus.imem_data)) begin
                    hold_op_nxt_s = bus.imem_data;
                    pc_nxt_s      = pc_inc_s;
                    bubble_s      = 1'b1;
                    state_nxt_s   = FETCH_IMM;
                end else begin
                    instr_nxt_s = bus.imem_data;
                    imm_nxt_s   = 16'h0000;
                    ppo_nxt_s   = pc_inc_s;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_inc_s;
                end
            end
            FETCH_IMM: begin
                if (bus.pc_write) begin
                    pc_nxt_s    = bus.pc_write_back_value;
                    bubble_s    = 1'b1;
                    state_nxt_s = FETCH_OP;
                end else if (bus.flush) begin
                    bubble_s    = 1'b1;
                    state_nxt_s = FETCH_OP;
                end else if (bus.stall) begin
                    state_nxt_s = state_r;
                end else begin
                    instr_nxt_s = hold_op_r;
                    imm_nxt_s   = bus.imem_data;
                    ppo_nxt_s   = pc_inc_s;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = FETCH_OP;
                end
            end
            default: begin
                // Unused encoding: drop whatever was in flight and resume fetching.
                bubble_s    = 1'b1;
                state_nxt_s = FETCH_OP;
            end
        endcase
    end

    // State, PC and IF/ID register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= BOOT;
            pc_r      <= {ADDR_W{1'b0}};
            hold_op_r <= 16'h0000;
            instr_r   <= NOP_WORD;
            imm_r     <= 16'h0000;
            ppo_r     <= {ADDR_W{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            hold_op_r <= hold_op_nxt_s;
            if (bubble_s) begin
                instr_r <= NOP_WORD;
                imm_r   <= 16'h0000;
                ppo_r   <= {ADDR_W{1'b0}};
                valid_r <= 1'b0;
            end else begin
                instr_r <= instr_nxt_s;
                imm_r   <= imm_nxt_s;
                ppo_r   <= ppo_nxt_s;
                valid_r <= valid_nxt_s;
            end
        end
    end

endmodule
